// File: rtl/exe_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the execution-unit result bus,
// the queued writeback entry and the source index constants.
package exe_wb_arbiter_pkg;

    typedef struct packed {
        logic        instruction_valid;
        logic        register_write;
        logic [4:0]  rd;
        logic [31:0] exe_result;
    } exe_wb_inf_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] exe_result;
    } wb_entry_t;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MUL = 1;
    localparam int WB_SRC_LSU = 2;

    // Only results that actually change architectural state are queued; x0 is never written.
    function automatic logic wb_qualifies(input exe_wb_inf_t inf);
        return inf.instruction_valid && inf.register_write && (inf.rd != 5'd0);
    endfunction

endpackage

// File: rtl/exe_wb_arbiter_wb_fifo.sv
// Per-source result queue: power-of-two depth, occupancy count 0..DEPTH,
// head entry presented combinationally on rdata.
module wb_fifo
    import exe_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        wdata,
    output wb_entry_t        rdata,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];
    logic             w_pop;

    assign w_pop = pop && (r_count != '0);
    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/exe_wb_arbiter.sv
// Sole owner of the register-file write port: queues results from each
// execution unit and retires one per cycle in round-robin order.
module exe_wb_arbiter
    import exe_wb_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = 3,
    parameter  int DEPTH   = 4,
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  exe_wb_inf_t       wb_inf_in [NUM_SRC],
    output logic              wb_stall,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [SRC_W-1:0]  rf_src
);

    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [NUM_SRC-1:0] w_nonempty;
    logic [CNT_W-1:0]   w_count [NUM_SRC];
    wb_entry_t          w_wdata [NUM_SRC];
    wb_entry_t          w_head  [NUM_SRC];
    logic               w_stall;
    logic               w_grant_vld;
    logic [SRC_W-1:0]   w_grant_idx;
    logic [SRC_W-1:0]   w_cand;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic               r_stall_q;

    // A producer frozen by last cycle's stall still shows an already-pushed result.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign w_push[gi]     = wb_qualifies(wb_inf_in[gi]) && !r_stall_q;
        assign w_pop[gi]      = w_grant_vld && (w_grant_idx == SRC_W'(gi));
        assign w_nonempty[gi] = (w_count[gi] != '0);
        assign w_wdata[gi]    = '{rd: wb_inf_in[gi].rd, exe_result: wb_inf_in[gi].exe_result};

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[gi]),
            .pop   (w_pop[gi]),
            .wdata (w_wdata[gi]),
            .rdata (w_head[gi]),
            .count (w_count[gi])
        );
    end

    always_comb begin
        w_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_count[i] >= CNT_W'(DEPTH - 1)) begin
                w_stall = 1'b1;
            end
        end
    end

    assign wb_stall = w_stall;

    // Scan from the farthest candidate back to r_rr_ptr so the nearest non-empty queue wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_cand = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (w_nonempty[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_q <= 1'b0;
            r_rr_ptr  <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            rf_src    <= '0;
        end else begin
            r_stall_q <= w_stall;
            rf_we     <= w_grant_vld;
            if (w_grant_vld) begin
                r_rr_ptr <= (w_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + SRC_W'(1);
                rf_waddr <= w_head[w_grant_idx].rd;
                rf_wdata <= w_head[w_grant_idx].exe_result;
                rf_src   <= w_grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Self-checking bench for exe_wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_exe_wb_arbiter;
    import exe_wb_arbiter_pkg::*;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exe_wb_inf_t wb_inf_in [NUM_SRC];
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  rf_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_wb_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_inf_in (wb_inf_in),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_src    (rf_src)
    );

    // Reference model: one plain queue per source, updated at each clock edge.
    logic [36:0] mq [NUM_SRC][$];
    bit          m_stall_q;
    int          m_rr;
    bit          exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    int          exp_src;

    function automatic bit model_stall();
        for (int i = 0; i < NUM_SRC; i++)
            if (mq[i].size() >= DEPTH - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_stall_q = 1'b0;
        m_rr      = 0;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_src   = 0;
    endtask

    task automatic model_edge();
        bit          stall_now;
        int          g;
        logic [36:0] e;
        stall_now = model_stall();
        g = -1;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = (m_rr + k) % NUM_SRC;
            if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        exp_we = (g >= 0);
        if (g >= 0) begin
            e = mq[g].pop_front();
            exp_waddr = e[36:32];
            exp_wdata = e[31:0];
            exp_src   = g;
            m_rr      = (g + 1) % NUM_SRC;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_inf_in[i].instruction_valid && wb_inf_in[i].register_write &&
                wb_inf_in[i].rd != 5'd0 && !m_stall_q)
                mq[i].push_back({wb_inf_in[i].rd, wb_inf_in[i].exe_result});
        end
        m_stall_q = stall_now;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else     model_edge();
        end
    end

    // Scoreboard: every cycle out of reset, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (rf_we !== exp_we) begin
                    errors++; $display("FAIL mon_rf_we t=%0t got %b want %b", $time, rf_we, exp_we);
                end
                checks++;
                if (rf_waddr !== exp_waddr) begin
                    errors++; $display("FAIL mon_rf_waddr t=%0t got %0d want %0d", $time, rf_waddr, exp_waddr);
                end
                checks++;
                if (rf_wdata !== exp_wdata) begin
                    errors++; $display("FAIL mon_rf_wdata t=%0t got %h want %h", $time, rf_wdata, exp_wdata);
                end
                checks++;
                if (rf_src !== 2'(exp_src)) begin
                    errors++; $display("FAIL mon_rf_src t=%0t got %0d want %0d", $time, rf_src, exp_src);
                end
                checks++;
                if (wb_stall !== model_stall()) begin
                    errors++; $display("FAIL mon_wb_stall t=%0t got %b want %b", $time, wb_stall, model_stall());
                end
            end
        end
    end

    task automatic drive(input int i, input bit v, input bit rw, input logic [4:0] rd, input logic [31:0] d);
        wb_inf_in[i].instruction_valid = v;
        wb_inf_in[i].register_write    = rw;
        wb_inf_in[i].rd                = rd;
        wb_inf_in[i].exe_result        = d;
    endtask

    task automatic drive_idle();
        for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rf_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%0d data=%h src=%0d want all 0", rf_we, rf_waddr, rf_wdata, rf_src);
        end
        checks++;
        if (wb_stall !== 1'b0) begin
            errors++; $display("FAIL reset_wb_stall got %b want 0", wb_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_alu();
        repeat (10) @(negedge clk);
        drive(WB_SRC_ALU, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        drive_idle();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL single_t1_we got %b want 0", rf_we);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || rf_src !== 2'd0) begin
            errors++;
            $display("FAIL single_t2_write got we=%b addr=%0d data=%h src=%0d want 1/5/deadbeef/0", rf_we, rf_waddr, rf_wdata, rf_src);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5) begin
            errors++; $display("FAIL single_t3_hold got we=%b addr=%0d want 0/5", rf_we, rf_waddr);
        end
    endtask

    task automatic test_drop();
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 1'b1, 5'd0, $urandom);
            drive(1, 1'b1, 1'b0, 5'd7, $urandom);
            drive(2, 1'b0, 1'b1, 5'd9, $urandom);
            @(negedge clk);
        end
        drive_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0 || wb_stall !== 1'b0) begin
                errors++; $display("FAIL drop_no_write got we=%b stall=%b want 0/0", rf_we, wb_stall);
            end
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b1, 1'b1, 5'(i + 1), $urandom);
        @(negedge clk);
        drive_idle();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rr_first_cycle_we got %b want 0", rf_we);
        end
        for (int c = 0; c < NUM_SRC; c++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b1 || rf_src !== 2'(c) || rf_waddr !== 5'(c + 1)) begin
                errors++;
                $display("FAIL rr_order_%0d got we=%b src=%0d addr=%0d want 1/%0d/%0d", c, rf_we, rf_src, rf_waddr, c, c + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rr_idle_we got %b want 0", rf_we);
        end
        for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b1, 1'b1, 5'(i + 4), $urandom);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_src !== 2'd0 || rf_waddr !== 5'd4) begin
            errors++; $display("FAIL rr_wrap_start got we=%b src=%0d addr=%0d want 1/0/4", rf_we, rf_src, rf_waddr);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        localparam int N = 20;
        int   alu_rd    = 0;
        int   other_n   = 0;
        bit   prev_stall = 1'b0;
        bit   saw_stall  = 1'b0;
        int   max_cnt    = 0;
        int   budget     = 0;
        int   got [$];
        while ((alu_rd <= N || got.size() < N) && budget < 400) begin
            if (rf_we === 1'b1 && rf_src === 2'd0) got.push_back(int'(rf_waddr));
            if (!prev_stall) begin
                alu_rd++;
                other_n++;
                if (alu_rd <= N) drive(0, 1'b1, 1'b1, 5'(alu_rd), $urandom);
                else             drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
                for (int i = 1; i < NUM_SRC; i++) begin
                    if (other_n <= N) drive(i, 1'b1, 1'b1, 5'($urandom_range(31, 1)), $urandom);
                    else              drive(i, 1'b0, 1'b0, 5'd0, 32'd0);
                end
            end
            prev_stall = wb_stall;
            if (wb_stall === 1'b1) saw_stall = 1'b1;
            if (int'(dut.g_src[0].u_fifo.r_count) > max_cnt) max_cnt = int'(dut.g_src[0].u_fifo.r_count);
            @(negedge clk);
            budget++;
        end
        drive_idle();
        checks++;
        if (budget >= 400) begin
            errors++; $display("FAIL bp_timeout got %0d alu retirements want %0d", got.size(), N);
        end
        checks++;
        if (got.size() != N) begin
            errors++; $display("FAIL bp_alu_count got %0d want %0d", got.size(), N);
        end
        for (int j = 0; j < got.size() && j < N; j++) begin
            checks++;
            if (got[j] != j + 1) begin
                errors++; $display("FAIL bp_alu_order_%0d got rd %0d want %0d", j, got[j], j + 1);
            end
        end
        checks++;
        if (saw_stall !== 1'b1) begin
            errors++; $display("FAIL bp_stall_seen got %b want 1", saw_stall);
        end
        checks++;
        if (max_cnt > DEPTH) begin
            errors++; $display("FAIL bp_max_count got %0d want <= %0d", max_cnt, DEPTH);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_random();
        bit prev_stall = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!prev_stall) begin
                for (int i = 0; i < NUM_SRC; i++)
                    drive(i, ($urandom_range(3, 0) != 0), ($urandom_range(7, 0) != 0),
                          5'($urandom_range(31, 0)), $urandom);
            end
            prev_stall = wb_stall;
            @(negedge clk);
        end
        drive_idle();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b1, 1'b1, 5'(c * 3 + i + 1), $urandom);
            @(negedge clk);
        end
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rf_src !== 2'd0 || wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_immediate got we=%b addr=%0d data=%h src=%0d stall=%b want all 0",
                     rf_we, rf_waddr, rf_wdata, rf_src, wb_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL midrst_no_write cycle %0d got we=%b addr=%0d want 0", c, rf_we, rf_waddr);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_single_alu();
        test_drop();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
